// File: rtl/frame_draw_sequencer.sv
// Per-frame draw controller: clears the framebuffer, streams points and expands each into a filled
// CELL x CELL block, and pulses step every TICK_FRAMES frames. FRAME_OVERRUN_CNT_EN adds overrun_cnt.
module frame_draw_sequencer #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned CELL        = 10,
  parameter int unsigned TICK_FRAMES = 6
) (
  input  logic       draw_clk,
  input  logic       reset,
  input  logic       frame_start,
  output logic       src_start,
  input  logic       pt_valid,
  input  logic [9:0] pt_x,
  input  logic [8:0] pt_y,
  input  logic [2:0] pt_color,
  input  logic       pt_last,
  output logic       pt_ready,
  output logic       step,
  output logic [9:0] fb_x,
  output logic [8:0] fb_y,
  output logic [2:0] fb_color,
  output logic       fb_we,
  output logic       busy,
`ifdef FRAME_OVERRUN_CNT_EN
  output logic [7:0] overrun_cnt,
`endif
  output logic       frame_done
);

  localparam int unsigned CntW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam logic [CntW-1:0] TickMax = CntW'(TICK_FRAMES - 1);
  localparam logic [9:0]  XMax    = 10'(SCREEN_W - 1);
  localparam logic [8:0]  YMax    = 9'(SCREEN_H - 1);
  localparam logic [10:0] WLim    = 11'(SCREEN_W);
  localparam logic [9:0]  HLim    = 10'(SCREEN_H);
  localparam logic [4:0]  CellMax = 5'(CELL - 1);

  typedef enum logic [2:0] {StIdle, StClear, StStart, StDraw, StBlock, StFinish} state_e;

  state_e          state_q;
  logic [4:0]      dx_q, dy_q;
  logic [9:0]      px_q;
  logic [8:0]      py_q;
  logic            plast_q;
  logic [CntW-1:0] frame_cnt_q;

  logic [4:0]  ndx, ndy;
  logic [10:0] bx;
  logic [9:0]  by;
  logic        blk_in, blk_end;

  // Coordinates of the next block pixel; in DRAW this is offset (0,0) of the incoming point.
  always_comb begin
    blk_end = (dx_q == CellMax) && (dy_q == CellMax);
    ndx     = (dx_q == CellMax) ? 5'd0 : dx_q + 5'd1;
    ndy     = (dx_q == CellMax) ? dy_q + 5'd1 : dy_q;
    if (state_q == StDraw) begin
      bx = {1'b0, pt_x};
      by = {1'b0, pt_y};
    end else begin
      bx = {1'b0, px_q} + {6'd0, ndx};
      by = {1'b0, py_q} + {5'd0, ndy};
    end
    blk_in = (bx < WLim) && (by < HLim);
  end

  always_ff @(posedge draw_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dx_q        <= '0;
      dy_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      plast_q     <= 1'b0;
      frame_cnt_q <= '0;
      src_start   <= 1'b0;
      pt_ready    <= 1'b0;
      step        <= 1'b0;
      fb_x        <= '0;
      fb_y        <= '0;
      fb_color    <= '0;
      fb_we       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef FRAME_OVERRUN_CNT_EN
      overrun_cnt <= '0;
`endif
    end else begin
      src_start  <= 1'b0;
      frame_done <= 1'b0;
      step       <= 1'b0;
`ifdef FRAME_OVERRUN_CNT_EN
      if (frame_start && busy && (overrun_cnt != 8'hff)) overrun_cnt <= overrun_cnt + 8'd1;
`endif
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q  <= StClear;
            busy     <= 1'b1;
            fb_we    <= 1'b1;
            fb_x     <= '0;
            fb_y     <= '0;
            fb_color <= '0;
          end
        end
        StClear: begin
          if (fb_x == XMax) begin
            fb_x <= '0;
            if (fb_y == YMax) begin
              state_q   <= StStart;
              fb_we     <= 1'b0;
              fb_y      <= '0;
              src_start <= 1'b1;
            end else begin
              fb_y <= fb_y + 9'd1;
            end
          end else begin
            fb_x <= fb_x + 10'd1;
          end
        end
        StStart: begin
          state_q  <= StDraw;
          pt_ready <= 1'b1;
        end
        StDraw: begin
          if (pt_valid) begin
            state_q  <= StBlock;
            pt_ready <= 1'b0;
            px_q     <= pt_x;
            py_q     <= pt_y;
            plast_q  <= pt_last;
            dx_q     <= '0;
            dy_q     <= '0;
            fb_x     <= bx[9:0];
            fb_y     <= by[8:0];
            fb_color <= pt_color;
            fb_we    <= blk_in;
          end
        end
        StBlock: begin
          if (blk_end) begin
            fb_we <= 1'b0;
            if (plast_q) begin
              state_q    <= StFinish;
              frame_done <= 1'b1;
              if (frame_cnt_q == TickMax) begin
                step        <= 1'b1;
                frame_cnt_q <= '0;
              end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
              end
            end else begin
              state_q  <= StDraw;
              pt_ready <= 1'b1;
            end
          end else begin
            dx_q  <= ndx;
            dy_q  <= ndy;
            fb_x  <= bx[9:0];
            fb_y  <= by[8:0];
            fb_we <= blk_in;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Bench for frame_draw_sequencer: directed and random frames checked against a pixel-list model.
module tb_frame_draw_sequencer;
  localparam int W = 20;
  localparam int H = 10;
  localparam int C = 2;
  localparam int T = 2;

  logic       draw_clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       src_start;
  logic       pt_valid;
  logic [9:0] pt_x;
  logic [8:0] pt_y;
  logic [2:0] pt_color;
  logic       pt_last;
  logic       pt_ready;
  logic       step;
  logic [9:0] fb_x;
  logic [8:0] fb_y;
  logic [2:0] fb_color;
  logic       fb_we;
  logic       busy;
  logic       frame_done;
`ifdef FRAME_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  frame_draw_sequencer #(
    .SCREEN_W(W), .SCREEN_H(H), .CELL(C), .TICK_FRAMES(T)
  ) dut (
    .draw_clk   (draw_clk),
    .reset      (reset),
    .frame_start(frame_start),
    .src_start  (src_start),
    .pt_valid   (pt_valid),
    .pt_x       (pt_x),
    .pt_y       (pt_y),
    .pt_color   (pt_color),
    .pt_last    (pt_last),
    .pt_ready   (pt_ready),
    .step       (step),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_color   (fb_color),
    .fb_we      (fb_we),
    .busy       (busy),
`ifdef FRAME_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .frame_done (frame_done)
  );

  always #5 draw_clk = ~draw_clk;

  int cyc = 0;
  always @(posedge draw_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [21:0] wr_q[$];
  int          wr_cyc[$];
  logic        fd_step_q[$];
  int          src_cnt = 0, src_cyc = 0, fd_cnt = 0, fd_cyc = 0, viol = 0;
  logic        prev_fd = 1'b0, prev_step = 1'b0;

  // Records every observed write and pulse, and counts protocol violations.
  always @(negedge draw_clk) begin
    if (!reset) begin
      if (fb_we) begin
        wr_q.push_back({fb_x, fb_y, fb_color});
        wr_cyc.push_back(cyc);
        if (pt_ready) viol++;
      end
      if (src_start) begin
        src_cnt++;
        src_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
        fd_step_q.push_back(step);
      end
      if (step && !frame_done) viol++;
      if ((frame_done && prev_fd) || (step && prev_step)) viol++;
      prev_fd   = frame_done;
      prev_step = step;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge draw_clk);
    #1;
  endtask

  int px[$], py[$], pc[$];
  int frame_idx = 0;
  int exp_ovr = 0;

  task automatic send_point(input int x, input int y, input int c, input bit last, output int h);
    int n;
    pt_valid = 1'b1;
    pt_x     = 10'(x);
    pt_y     = 9'(y);
    pt_color = 3'(c);
    pt_last  = last;
    n = 0;
    while (!pt_ready && n < 100) begin
      tick();
      n++;
    end
    chk("pt_ready_timeout", 32'(n < 100), 32'd1);
    @(posedge draw_clk);
    #1;
    h = cyc;
    pt_valid = 1'b0;
  endtask

  task automatic run_frame(input bit inject);
    logic [21:0] exp_q[$];
    int start_cyc, h, n, base;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) exp_q.push_back({10'(x), 9'(y), 3'd0});
    for (int i = 0; i < px.size(); i++)
      for (int dy = 0; dy < C; dy++)
        for (int dx = 0; dx < C; dx++)
          if (px[i] + dx < W && py[i] + dy < H)
            exp_q.push_back({10'(px[i] + dx), 9'(py[i] + dy), 3'(pc[i])});
    wr_q.delete();
    wr_cyc.delete();
    fd_step_q.delete();
    src_cnt = 0;
    fd_cnt  = 0;

    start_cyc   = cyc;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (inject) begin
      repeat (10) tick();
      repeat (3) begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
      end
      exp_ovr += 3;
    end
    n = 0;
    while (src_cnt == 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("src_start_count", 32'(src_cnt), 32'd1);
    chk("clear_writes", 32'(wr_q.size()), 32'(W * H));
    if (wr_cyc.size() > 0) begin
      chk("clear_first_cyc", 32'(wr_cyc[0]), 32'(start_cyc + 1));
      chk("clear_last_cyc", 32'(wr_cyc[wr_cyc.size()-1]), 32'(start_cyc + W * H));
    end
    chk("src_start_cyc", 32'(src_cyc), 32'(start_cyc + 1 + W * H));
    chk("busy_in_frame", 32'(busy), 32'd1);
`ifdef FRAME_OVERRUN_CNT_EN
    chk("overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr));
`endif
    tick();
    base = wr_q.size();
    repeat (5) begin
      chk("draw_wait_ready", 32'(pt_ready), 32'd1);
      tick();
    end
    chk("draw_wait_nowrite", 32'(wr_q.size()), 32'(base));
    h = 0;
    for (int i = 0; i < px.size(); i++) begin
      send_point(px[i], py[i], pc[i], i == px.size() - 1, h);
      if (i != px.size() - 1) chk("ready_low_in_block", 32'(pt_ready), 32'd0);
    end
    n = 0;
    while (fd_cnt == 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("frame_done_count", 32'(fd_cnt), 32'd1);
    chk("frame_done_cyc", 32'(fd_cyc), 32'(h + C * C));
    if (fd_step_q.size() > 0)
      chk("step_with_done", 32'(fd_step_q[0]), 32'((frame_idx % T) == T - 1));
    chk("writes_total", 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) chk("write_pixel", 32'(wr_q[i]), 32'(exp_q[i]));
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(frame_done), 32'd0);
    chk("idle_step", 32'(step), 32'd0);
    frame_idx++;
  endtask

  task automatic set_points(input int n);
    px.delete();
    py.delete();
    pc.delete();
    for (int i = 0; i < n; i++) begin
      px.push_back(int'($urandom_range(W + 1, 0)));
      py.push_back(int'($urandom_range(H + 1, 0)));
      pc.push_back(int'($urandom_range(7, 0)));
    end
  endtask

  task automatic one_point(input int x, input int y, input int c);
    px.delete();
    py.delete();
    pc.delete();
    px.push_back(x);
    py.push_back(y);
    pc.push_back(c);
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    pt_valid    = 1'b0;
    pt_x        = '0;
    pt_y        = '0;
    pt_color    = '0;
    pt_last     = 1'b0;
    tick();
    tick();
    chk("rst_outputs", 32'({src_start, pt_ready, step, fb_x, fb_y, fb_color, fb_we, busy, frame_done}), 32'd0);
`ifdef FRAME_OVERRUN_CNT_EN
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
`endif
    reset = 1'b0;
    tick();

    one_point(4, 6, 5);
    run_frame(1'b0);
    run_frame(1'b0);
    run_frame(1'b0);
    one_point(19, 9, 3);
    run_frame(1'b0);

    px.delete();
    py.delete();
    pc.delete();
    px.push_back(0);  py.push_back(0); pc.push_back(1);
    px.push_back(10); py.push_back(4); pc.push_back(2);
    px.push_back(16); py.push_back(2); pc.push_back(7);
    run_frame(1'b1);

    for (int f = 0; f < 4; f++) begin
      set_points(int'($urandom_range(3, 1)));
      run_frame(f == 2);
    end

    // Abort mid-clear; frame counter must restart from zero.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (30) tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_outputs", 32'({src_start, pt_ready, step, fb_x, fb_y, fb_color, fb_we, busy, frame_done}), 32'd0);
`ifdef FRAME_OVERRUN_CNT_EN
    chk("abort_overrun", 32'(overrun_cnt), 32'd0);
`endif
    exp_ovr = 0;
    tick();
    reset = 1'b0;
    tick();
    frame_idx = 0;
    one_point(4, 6, 5);
    run_frame(1'b0);

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_draw_sequencer.md
Name: frame_draw_sequencer

Overview:
- Per-frame controller for the snake display path. On each frame-start pulse it clears the framebuffer, then requests a fresh coordinate stream from the snake/food point source. Each received point is expanded into a CELL x CELL filled block of framebuffer writes.
- Every TICK_FRAMES frames it issues a one-cycle step pulse that advances the snake.
- It is the single owner of the framebuffer write port.

Parameters:
- SCREEN_W, 640, visible width in pixels (max 1023)
- SCREEN_H, 480, visible height in pixels (max 511)
- CELL, 10, block edge length in pixels per point (1..32)
- TICK_FRAMES, 6, frames per snake step (>=1)

Ports:
- draw_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- src_start  out  1  one-cycle pulse; point source restarts its stream
- pt_valid  in  1  point available
- pt_x  in  10  block top-left x
- pt_y  in  9  block top-left y
- pt_color  in  3  block colour
- pt_last  in  1  qualifies final point of stream
- pt_ready  out  1  sequencer accepts point this cycle
- step  out  1  one-cycle pulse: advance snake
- fb_x  out  10  framebuffer write x
- fb_y  out  9  framebuffer write y
- fb_color  out  3  framebuffer write colour
- fb_we  out  1  framebuffer write enable
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame work

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock draw_clk. All outputs are registered.
- Reset values:
  - All outputs 0; state IDLE; frame counter 0; block offsets 0.
  - Reset asserted mid-operation aborts immediately; there is no partial-frame completion.
- States: IDLE, CLEAR, START, DRAW, BLOCK, FINISH.
- IDLE:
  - frame_start=1 -> CLEAR. In the next cycle fb_we=1, fb_x=0, fb_y=0, fb_color=0.
- CLEAR:
  - Raster sweep, one pixel per cycle, x fastest.
  - Covers (0,0)..(SCREEN_W-1,SCREEN_H-1); exactly SCREEN_W*SCREEN_H writes, colour 0.
  - After the final pixel -> START.
- START:
  - src_start=1 for exactly one cycle; fb_we=0; then -> DRAW.
- DRAW:
  - pt_ready=1.
  - Handshake completes when pt_valid&pt_ready. On completion, latch pt_x/pt_y/pt_color/pt_last and go to BLOCK.
  - pt_ready=0 in every other state, so no point is accepted while a block is in progress.
- BLOCK:
  - Emits CELL*CELL cycles, offsets dx fastest then dy, each 0..CELL-1.
  - fb_x=pt_x+dx, fb_y=pt_y+dy, computed at 11/10 bits internally so there is no wrap-around.
  - Pixels with x>=SCREEN_W or y>=SCREEN_H still take their cycle but drive fb_we=0.
  - After the last offset: latched pt_last=1 -> FINISH, else -> DRAW.
- FINISH (one cycle):
  - frame_done=1.
  - If frame counter==TICK_FRAMES-1: step=1 and counter<=0; else counter<=counter+1.
  - Then -> IDLE.
- frame_start while not in IDLE is ignored; the frame is dropped and not queued.
- Simultaneous frame_start and reaching IDLE: frame_start is honoured only when sampled while already in IDLE.
- fb_we is never asserted outside CLEAR/BLOCK. step and frame_done are never high for more than one cycle.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro FRAME_OVERRUN_CNT_EN.
- Defined:
  - Adds output overrun_cnt[7:0], reset 0.
  - Increments by 1 on each frame_start sampled while busy=1; saturates at 255.
- Undefined:
  - Port and counter are absent; dropped frame_start pulses are silently ignored.

Test Plan:
- SCREEN_W=20, SCREEN_H=10, CELL=2, TICK_FRAMES=2. Pulse frame_start -> exactly 200 consecutive fb_we cycles, colour 0, (0,0) through (19,9) in raster order, then a single src_start pulse.
- Stream one point (4,6,colour 5,last=1) -> writes (4,6),(5,6),(4,7),(5,7) colour 5, then frame_done pulse; step=0 on frame 1.
- Second identical frame -> step=1 in the same cycle as frame_done; third frame -> step=0 (counter wrapped).
- Point (19,9,last=1) -> only (19,9) written. Four BLOCK cycles elapse with fb_we low for the three out-of-range pixels.
- Hold pt_valid low for 5 cycles in DRAW -> pt_ready stays 1, no writes. Three points with last on the third -> 12 writes, pt_ready low during each block.
- Assert reset mid-CLEAR -> all outputs 0 immediately. With FRAME_OVERRUN_CNT_EN, 3 frame_start pulses during CLEAR -> overrun_cnt=3, frame not restarted.
